// File: rtl/fiber_bus_master.sv
// fiber_bus_master: FIBER_BUS initiator turning Aurora request packets into bus beats and response packets
module fiber_bus_master #(
   parameter int TIMEOUT   = 255,
   parameter int ADDR_STEP = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LINK_UP,
   input  logic        REQ_EMPTY,
   input  logic [31:0] REQ_DATA,
   output logic        REQ_RD,
   input  logic        RSP_FULL,
   output logic        RSP_WR,
   output logic [31:0] RSP_DATA,
   output logic        RSP_END,
   output logic [31:0] FIBER_BUS_ADDR,
   output logic [31:0] FIBER_BUS_DOUT,
   input  logic [31:0] FIBER_BUS_DIN,
   output logic        FIBER_BUS_WR,
   output logic        FIBER_BUS_RD,
   input  logic        FIBER_BUS_ACK,
   output logic        BUSY
);
   typedef enum logic [2:0] {IDLE, ADDR, WFETCH, RWAIT, STROBE, GAP, DRAIN, TRAILER} state_t;
   state_t      state, state_nx;
   logic        is_wr, err, tmo, unused_hdr;
   logic [7:0]  tag;
   logic [15:0] rem, done, tcnt;
   logic [31:0] rdata;
   assign unused_hdr   = ^REQ_DATA[30:24];
   assign tmo          = state == STROBE && !FIBER_BUS_ACK && tcnt == 16'(TIMEOUT - 1);
   assign FIBER_BUS_WR = state == STROBE && is_wr;
   assign FIBER_BUS_RD = state == STROBE && !is_wr;
   assign BUSY         = state != IDLE;
   assign RSP_END      = state == TRAILER && !RSP_FULL && !RST;
   assign RSP_WR       = RSP_END || (state == GAP && !is_wr && !RST);
   assign RSP_DATA     = state == TRAILER ? {is_wr, err, 6'd0, tag, done} :
                         state == GAP && !is_wr ? rdata : 32'd0;
   // next-state and FIFO pop decode; pops are held off during reset so FIFOs stay untouched
   always_comb begin
      state_nx = state;
      REQ_RD   = 1'b0;
      case (state)
         IDLE:    if (LINK_UP && !REQ_EMPTY) begin
                     REQ_RD   = 1'b1;
                     state_nx = ADDR;
                  end
         ADDR:    if (!REQ_EMPTY) begin
                     REQ_RD   = 1'b1;
                     state_nx = is_wr ? WFETCH : RWAIT;
                  end
         WFETCH:  if (!REQ_EMPTY) begin
                     REQ_RD   = 1'b1;
                     state_nx = STROBE;
                  end
         RWAIT:   state_nx = RSP_FULL ? RWAIT : STROBE;
         STROBE:  state_nx = FIBER_BUS_ACK ? GAP : tmo ? (is_wr ? DRAIN : TRAILER) : STROBE;
         GAP:     state_nx = rem == 16'd0 ? TRAILER : is_wr ? WFETCH : RWAIT;
         DRAIN:   if (rem == 16'd0) state_nx = TRAILER;
                  else REQ_RD = !REQ_EMPTY;
         TRAILER: state_nx = RSP_FULL ? TRAILER : IDLE;
         default: state_nx = IDLE;
      endcase
      if (RST) REQ_RD = 1'b0;
   end
   // packet context, bus registers, beat/timeout counters
   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= IDLE;
         is_wr          <= 1'b0;
         err            <= 1'b0;
         tag            <= 8'd0;
         rem            <= 16'd0;
         done           <= 16'd0;
         tcnt           <= 16'd0;
         rdata          <= 32'd0;
         FIBER_BUS_ADDR <= 32'd0;
         FIBER_BUS_DOUT <= 32'd0;
      end else begin
         state <= state_nx;
         tcnt  <= state == STROBE ? tcnt + 16'd1 : 16'd0;
         if (state == IDLE && REQ_RD) begin
            is_wr <= REQ_DATA[31];
            tag   <= REQ_DATA[23:16];
            rem   <= REQ_DATA[15:0] == 16'd0 ? 16'd0 : REQ_DATA[15:0] - 16'd1;
            done  <= 16'd0;
            err   <= 1'b0;
         end
         if (state == ADDR && REQ_RD) FIBER_BUS_ADDR <= REQ_DATA;
         if (state == WFETCH && REQ_RD) FIBER_BUS_DOUT <= REQ_DATA;
         if (state == DRAIN && REQ_RD) rem <= rem - 16'd1;
         if (state == STROBE && FIBER_BUS_ACK) begin
            rdata <= FIBER_BUS_DIN;
            done  <= done + 16'd1;
         end
         if (tmo) err <= 1'b1;
         if (state == GAP && rem != 16'd0) begin
            rem            <= rem - 16'd1;
            FIBER_BUS_ADDR <= FIBER_BUS_ADDR + 32'(ADDR_STEP);
         end
      end
   end
endmodule
